// File: rtl/fb_plot_sequencer.sv
// Frame-buffer plot sequencer: walks the frozen frame in raster or serpentine
// order, borrowing the shared read port during VGA blanking, and hands pen decisions to the plotter.
module fb_plot_sequencer #(
  parameter int H_PIX  = 320,
  parameter int V_PIX  = 240,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 11,
  parameter int RD_LAT = 2,
  parameter int THRESH = 16
) (
  input  logic              clk_65mhz,
  input  logic              cpu_resetn,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic              serp_in,
  input  logic              bus_free_in,
  output logic              fb_rd_out,
  output logic [ADDR_W-1:0] fb_addr_out,
  input  logic [PIX_W-1:0]  fb_data_in,
  output logic              pixel_valid_out,
  output logic              pixel_value_out,
  output logic [8:0]        x_out,
  output logic [7:0]        y_out,
  input  logic              ready_next_pixel_in,
  output logic              freeze_out,
  output logic              busy_out,
  output logic              done_out
);

  typedef enum logic [2:0] {IDLE, FREEZE, ISSUE, WAIT, PRESENT, DONE} state_t;

  state_t            state, state_n;
  logic              serp_q;
  logic [8:0]        x;
  logic [7:0]        y;
  logic [ADDR_W-1:0] base;
  logic [7:0]        lat_cnt;
  logic [4:0]        gray;
  logic              descend, row_end, last_pix, lat_done, aborting;

  assign gray     = fb_data_in[PIX_W-1 -: 5];
  assign descend  = serp_q & y[0];
  assign row_end  = descend ? (x == '0) : (x == 9'(H_PIX - 1));
  assign last_pix = row_end && (y == 8'(V_PIX - 1));
  assign lat_done = (lat_cnt == 8'(RD_LAT - 1));
  assign aborting = abort_in && (state != IDLE);

  // Row base accumulates H_PIX per row so the address needs only an adder.
  assign fb_addr_out = base + ADDR_W'(x);
  assign x_out       = x;
  assign y_out       = y;

  always_ff @(posedge clk_65mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) state <= IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n   = state;
    fb_rd_out = 1'b0;
    busy_out  = (state != IDLE);
    case (state)
      IDLE:    if (start_in) state_n = FREEZE;
      FREEZE:  state_n = ISSUE;
      ISSUE: begin
        fb_rd_out = bus_free_in && !abort_in;
        if (bus_free_in) state_n = WAIT;
      end
      WAIT:    if (lat_done) state_n = PRESENT;
      PRESENT: if (ready_next_pixel_in) state_n = last_pix ? DONE : ISSUE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (aborting) state_n = IDLE;
  end

  always_ff @(posedge clk_65mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      serp_q          <= 1'b0;
      x               <= '0;
      y               <= '0;
      base            <= '0;
      lat_cnt         <= '0;
      pixel_valid_out <= 1'b0;
      pixel_value_out <= 1'b0;
      freeze_out      <= 1'b0;
      done_out        <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            serp_q     <= serp_in;
            x          <= '0;
            y          <= '0;
            base       <= '0;
            freeze_out <= 1'b1;
          end
        end
        ISSUE: lat_cnt <= '0;
        WAIT: begin
          if (lat_done) begin
            pixel_value_out <= (int'(gray) < THRESH);
            pixel_valid_out <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        PRESENT: begin
          if (ready_next_pixel_in) begin
            pixel_valid_out <= 1'b0;
            if (last_pix) begin
              freeze_out <= 1'b0;
              done_out   <= 1'b1;
            end else if (!row_end) begin
              x <= descend ? x - 9'd1 : x + 9'd1;
            end else begin
              // Serpentine keeps x at the edge; the new row runs the other way.
              y    <= y + 8'd1;
              base <= base + ADDR_W'(H_PIX);
              if (!serp_q) x <= '0;
            end
          end
        end
        default: ;
      endcase
      if (aborting) begin
        pixel_valid_out <= 1'b0;
        freeze_out      <= 1'b0;
        done_out        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_plot_sequencer.sv
// Bench for fb_plot_sequencer on a 4x3 frame: expected pixel order, addresses,
// pen values and handshake timing come from a plain visit-order model.
module tb_fb_plot_sequencer;

  localparam int H      = 4;
  localparam int V      = 3;
  localparam int N      = H * V;
  localparam int ADDR_W = 17;
  localparam int PIX_W  = 11;
  localparam int RD_LAT = 2;
  localparam int THRESH = 16;

  logic              clk_65mhz = 1'b0;
  logic              cpu_resetn, start_in, abort_in, serp_in, bus_free_in;
  logic              fb_rd_out;
  logic [ADDR_W-1:0] fb_addr_out;
  logic [PIX_W-1:0]  fb_data_in;
  logic              pixel_valid_out, pixel_value_out;
  logic [8:0]        x_out;
  logic [7:0]        y_out;
  logic              ready_next_pixel_in;
  logic              freeze_out, busy_out, done_out;

  int total = 0;
  int bad   = 0;

  logic [PIX_W-1:0] mem [N];
  logic [PIX_W-1:0] d1, d2;

  fb_plot_sequencer #(
    .H_PIX(H), .V_PIX(V), .ADDR_W(ADDR_W), .PIX_W(PIX_W),
    .RD_LAT(RD_LAT), .THRESH(THRESH)
  ) dut (
    .clk_65mhz(clk_65mhz), .cpu_resetn(cpu_resetn), .start_in(start_in),
    .abort_in(abort_in), .serp_in(serp_in), .bus_free_in(bus_free_in),
    .fb_rd_out(fb_rd_out), .fb_addr_out(fb_addr_out), .fb_data_in(fb_data_in),
    .pixel_valid_out(pixel_valid_out), .pixel_value_out(pixel_value_out),
    .x_out(x_out), .y_out(y_out), .ready_next_pixel_in(ready_next_pixel_in),
    .freeze_out(freeze_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk_65mhz = ~clk_65mhz;

  // Two-stage BRAM: address captured at one edge, data valid after the next.
  always_ff @(posedge clk_65mhz) begin
    d1 <= (fb_addr_out < N) ? mem[fb_addr_out] : '0;
    d2 <= d1;
  end
  assign fb_data_in = d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_65mhz);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < N; i++) mem[i] = PIX_W'($urandom);
  endtask

  function automatic logic pen(input int a);
    return (int'(mem[a] >> (PIX_W - 5)) < THRESH);
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd"},    fb_rd_out, 0);
    chk({tag, "_addr"},  fb_addr_out, 0);
    chk({tag, "_valid"}, pixel_valid_out, 0);
    chk({tag, "_value"}, pixel_value_out, 0);
    chk({tag, "_x"},     x_out, 0);
    chk({tag, "_y"},     y_out, 0);
    chk({tag, "_freeze"}, freeze_out, 0);
    chk({tag, "_busy"},  busy_out, 0);
    chk({tag, "_done"},  done_out, 0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !pixel_valid_out; i++) step();
    chk({tag, "_valid_timeout"}, pixel_valid_out, 1);
  endtask

  task automatic run_plot(input bit serp, input int free_pct, input int rdy_pct, input bit chk_lat);
    int ex[$], ey[$], ea[$];
    int n_rd = 0, n_acc = 0, last_rd = 0, c;
    bit prev_valid = 0;
    for (int r = 0; r < V; r++)
      for (int k = 0; k < H; k++) begin
        int col = (serp && (r % 2 == 1)) ? H - 1 - k : k;
        ex.push_back(col);
        ey.push_back(r);
        ea.push_back(r * H + col);
      end
    serp_in = serp; start_in = 1; bus_free_in = 1; ready_next_pixel_in = 0;
    step();
    start_in = 0;
    serp_in  = ~serp;
    c = 1;
    while (n_acc < N && c < 3000) begin
      bus_free_in         = ($urandom_range(99) < free_pct);
      ready_next_pixel_in = ($urandom_range(99) < rdy_pct);
      #1;
      chk("rd_without_bus", fb_rd_out & ~bus_free_in, 0);
      chk("freeze_held", freeze_out, 1);
      chk("busy_held", busy_out, 1);
      chk("early_done", done_out, 0);
      if (fb_rd_out) begin
        chk("one_read_per_pixel", n_rd, n_acc);
        if (n_rd < N) chk("rd_addr", fb_addr_out, ea[n_rd]);
        if (chk_lat && n_rd == 0) chk("first_rd_cycle", c, 2);
        last_rd = c;
        n_rd++;
      end
      if (pixel_valid_out) begin
        chk("valid_after_read", n_rd, n_acc + 1);
        if (!prev_valid) chk("rd_to_valid", c - last_rd, RD_LAT + 1);
        if (chk_lat && n_acc == 0 && !prev_valid) chk("start_to_valid", c, 3 + RD_LAT);
        chk("x_out", x_out, ex[n_acc]);
        chk("y_out", y_out, ey[n_acc]);
        chk("pen", pixel_value_out, pen(ea[n_acc]));
        if (ready_next_pixel_in) n_acc++;
      end
      prev_valid = pixel_valid_out && !ready_next_pixel_in;
      step();
      c++;
    end
    chk("plot_complete", n_acc, N);
    chk("read_count", n_rd, N);
    bus_free_in = 1; ready_next_pixel_in = 0;
    #1;
    chk("done_pulse", done_out, 1);
    chk("done_freeze", freeze_out, 0);
    chk("done_valid", pixel_valid_out, 0);
    step();
    chk("done_one_cycle", done_out, 0);
    chk("idle_after_done", busy_out, 0);
  endtask

  initial begin
    cpu_resetn = 1; start_in = 0; abort_in = 0; serp_in = 0;
    bus_free_in = 0; ready_next_pixel_in = 0;
    fill_mem();
    #2 cpu_resetn = 0;
    #1 check_idle_outputs("reset");
    @(posedge clk_65mhz);
    @(posedge clk_65mhz);
    #2 cpu_resetn = 1;
    step();
    chk("idle_post_reset", busy_out, 0);

    run_plot(0, 100, 100, 1);
    run_plot(1, 100, 100, 1);

    // Read port withheld for 20 cycles while in ISSUE.
    fill_mem();
    serp_in = 0; bus_free_in = 0; ready_next_pixel_in = 0; start_in = 1;
    step();
    start_in = 0;
    step();
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("stall_rd", fb_rd_out, 0);
      chk("stall_busy", busy_out, 1);
      chk("stall_valid", pixel_valid_out, 0);
      step();
    end
    bus_free_in = 1;
    #1;
    chk("stall_rd_pulse", fb_rd_out, 1);
    chk("stall_addr", fb_addr_out, 0);
    step();
    chk("stall_rd_single", fb_rd_out, 0);
    chk("stall_valid_lat1", pixel_valid_out, 0);
    step();
    chk("stall_valid_lat2", pixel_valid_out, 0);
    step();
    chk("stall_valid_lat3", pixel_valid_out, 1);
    chk("stall_pen", pixel_value_out, pen(0));
    abort_in = 1;
    step();
    abort_in = 0;
    chk("stall_abort_idle", busy_out, 0);

    // Threshold boundary and hold-while-not-ready.
    mem[0] = {5'd15, 6'h3F};
    mem[1] = {5'd16, 6'h00};
    serp_in = 0; bus_free_in = 1; ready_next_pixel_in = 0; start_in = 1;
    step();
    start_in = 0;
    wait_valid("thr0");
    chk("gray15_pen", pixel_value_out, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", pixel_valid_out, 1);
      chk("hold_value", pixel_value_out, 1);
      chk("hold_x", x_out, 0);
      chk("hold_y", y_out, 0);
    end
    ready_next_pixel_in = 1;
    step();
    ready_next_pixel_in = 0;
    wait_valid("thr1");
    chk("gray16_pen", pixel_value_out, 0);
    chk("gray16_x", x_out, 1);
    abort_in = 1;
    step();
    abort_in = 0;

    // Abort during WAIT, then a fresh plot from address 0.
    bus_free_in = 1; start_in = 1;
    step();
    start_in = 0;
    step();
    step();
    abort_in = 1; ready_next_pixel_in = 1; start_in = 1;
    step();
    abort_in = 0; ready_next_pixel_in = 0; start_in = 0;
    chk("abort_busy", busy_out, 0);
    chk("abort_freeze", freeze_out, 0);
    chk("abort_valid", pixel_valid_out, 0);
    chk("abort_done", done_out, 0);
    step();
    chk("abort_no_done", done_out, 0);
    fill_mem();
    run_plot(0, 100, 100, 1);

    for (int t = 0; t < 4; t++) begin
      fill_mem();
      run_plot(1'($urandom_range(1)), 60, 50, 0);
    end

    // Asynchronous reset while a pixel is being presented.
    serp_in = 0; bus_free_in = 1; ready_next_pixel_in = 0; start_in = 1;
    step();
    start_in = 0;
    wait_valid("rst_mid");
    #2 cpu_resetn = 0;
    #1 check_idle_outputs("async_reset");
    #2 cpu_resetn = 1;
    step();
    chk("after_reset_idle", busy_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
